// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU.
//   - 4-bit alucontrol operation codes (also used by the ALU control decoder)
//   - FSM state enum for alu_exec
//   - is_shift(): true for the multi-cycle shift operations
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SLT  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// -----------------------------------------------------------------------------
// alu_exec_if
// Request/response bundle for alu_exec.
//   master (requester): drives in_valid, alucontrol, a, b, out_ready
//   slave  (alu_exec) : drives in_ready, out_valid, result, zero, err
// -----------------------------------------------------------------------------
interface alu_exec_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alucontrol;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         err;

    modport master (
        output in_valid, alucontrol, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, alucontrol, a, b, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Combinational single-cycle ALU operations (everything except shifts).
// Ports:
//   alucontrol : operation code
//   a, b       : operands
//   result     : operation result (0 for shift and unsupported codes)
//   err        : high for codes this block and the shifter do not implement
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [3:0]   alucontrol,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (alucontrol)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(N-1){1'b0}}, (a < b)};
            // Shifts are sequenced by alu_exec; they are legal codes here.
            ALU_SLL, ALU_SRL, ALU_SRA: result = '0;
            default:  err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// Execute-stage ALU with valid/ready handshakes. Non-shift ops complete in one
// cycle; shifts step one bit per cycle for the requested amount.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alu_exec_if.slave (in_valid/in_ready, alucontrol, a, b,
//             out_valid/out_ready, result, zero, err)
// -----------------------------------------------------------------------------
module alu_exec
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    alu_exec_if.slave  bus
);

    localparam int SW = $clog2(N);

    state_t         state_reg;
    logic [3:0]     op_reg;
    logic [SW-1:0]  cnt_reg;
    logic [N-1:0]   result_reg;
    logic           zero_reg;
    logic           err_reg;
    logic           out_valid_reg;
    logic           in_ready_reg;

    logic [N-1:0]   core_result;
    logic           core_err;
    logic [N-1:0]   step_next;
    logic [SW-1:0]  amt;

    assign amt = bus.b[SW-1:0];

    alu_core #(.N(N)) u_core (
        .alucontrol (bus.alucontrol),
        .a          (bus.a),
        .b          (bus.b),
        .result     (core_result),
        .err        (core_err)
    );

    // One shift step; result_reg doubles as the shift register while in SHIFT.
    always_comb begin
        step_next = result_reg;
        case (op_reg)
            ALU_SLL: step_next = {result_reg[N-2:0], 1'b0};
            ALU_SRL: step_next = {1'b0, result_reg[N-1:1]};
            ALU_SRA: step_next = {result_reg[N-1], result_reg[N-1:1]};
            default: step_next = result_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_reg       <= bus.alucontrol;
                        in_ready_reg <= 1'b0;
                        err_reg      <= 1'b0;
                        if (is_shift(bus.alucontrol) && (amt != '0)) begin
                            state_reg  <= SHIFT;
                            result_reg <= bus.a;
                            cnt_reg    <= amt;
                        end else if (is_shift(bus.alucontrol)) begin
                            // Zero-length shift passes a straight through.
                            state_reg     <= DONE;
                            result_reg    <= bus.a;
                            zero_reg      <= (bus.a == '0);
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= DONE;
                            result_reg    <= core_result;
                            zero_reg      <= (core_result == '0);
                            err_reg       <= core_err;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    result_reg <= step_next;
                    cnt_reg    <= cnt_reg - 1'b1;
                    if (cnt_reg == SW'(1)) begin
                        state_reg     <= DONE;
                        zero_reg      <= (step_next == '0);
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // Outputs hold until the consumer takes them.
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.err       = err_reg;

endmodule
